// File: rtl/multi_debouncer.sv
// N-channel button/switch debouncer: 2-flop synchroniser, tick-gated stability counter
// and optional post-accept holdoff per channel, with registered level and edge pulses.
module multi_debouncer #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned STABLE_CNT = 4095,
    parameter int unsigned HOLDOFF    = 0,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           tick,
    input  logic [NCH-1:0] rawIn,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           anyRise
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF);

    logic [NCH-1:0]            s1_q;
    logic [NCH-1:0]            s2_q;
    logic [NCH-1:0]            level_q;
    logic [NCH-1:0]            level_d;
    logic [NCH-1:0]            rise_q;
    logic [NCH-1:0]            rise_d;
    logic [NCH-1:0]            fall_q;
    logic [NCH-1:0]            fall_d;
    logic                      any_rise_q;
    logic                      any_rise_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_d;
    logic [NCH-1:0][CNT_W-1:0] hold_q;
    logic [NCH-1:0][CNT_W-1:0] hold_d;

    // Synchroniser runs every clk; the filter only ever looks at s2.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_q <= {NCH{RST_VAL}};
            s2_q <= {NCH{RST_VAL}};
        end else begin
            s1_q <= rawIn;
            s2_q <= s1_q;
        end
    end

    // Per-channel filter: holdoff beats noise reset beats accept beats count.
    always_comb begin
        level_d = level_q;
        rise_d  = {NCH{1'b0}};
        fall_d  = {NCH{1'b0}};
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        for (int i = 0; i < NCH; i++) begin
            if (hold_q[i] != CNT_ZERO) begin
                cnt_d[i] = CNT_ZERO;
                if (tick) begin
                    hold_d[i] = hold_q[i] - CNT_ONE;
                end else begin
                    hold_d[i] = hold_q[i];
                end
            end else if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = CNT_ZERO;
                hold_d[i]  = HOLD_INIT;
                rise_d[i]  = s2_q[i];
                fall_d[i]  = ~s2_q[i];
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        any_rise_d = |rise_d;
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            level_q    <= {NCH{RST_VAL}};
            rise_q     <= {NCH{1'b0}};
            fall_q     <= {NCH{1'b0}};
            any_rise_q <= 1'b0;
            cnt_q      <= {(NCH*CNT_W){1'b0}};
            hold_q     <= {(NCH*CNT_W){1'b0}};
        end else begin
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= any_rise_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign anyRise = any_rise_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer (NCH=4, STABLE_CNT=4, HOLDOFF=2): expected
// per-edge outputs are queued as stimulus is driven and popped after each edge.
module tb_multi_debouncer;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] r;
        logic [3:0] f;
        logic       a;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] rawIn = 4'h0;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       anyRise;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multi_debouncer #(
        .NCH(4), .CNT_W(12), .STABLE_CNT(4), .HOLDOFF(2), .RST_VAL(1'b0)
    ) dut (
        .clk(clk), .rstN(rstN), .tick(tick), .rawIn(rawIn),
        .level(level), .rise(rise), .fall(fall), .anyRise(anyRise)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] lvl, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.lvl = lvl;
        e.r   = r;
        e.f   = f;
        e.a   = |r;
        return e;
    endfunction

    task automatic do_reset();
        rstN  = 1'b0;
        rawIn = 4'h0;
        tick  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        rawIn = 4'hF;
        tick  = 1'b1;
        rstN  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            sb.push_back(mk(4'h0, 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_hold edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
        rstN = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            sb.push_back(mk((c >= 6) ? 4'hF : 4'h0, (c == 6) ? 4'hF : 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_release edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    task automatic test_rise_fall();
        exp_t e;
        exp_t got;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            rawIn = (c <= 10) ? 4'h1 : 4'h0;
            sb.push_back(mk((c >= 6 && c < 16) ? 4'h1 : 4'h0,
                            (c == 6) ? 4'h1 : 4'h0, (c == 16) ? 4'h1 : 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rise_fall edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        exp_t got;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            rawIn = ((c <= 3) || (c >= 11 && c <= 14)) ? 4'h2 : 4'h0;
            sb.push_back(mk((c >= 16 && c < 22) ? 4'h2 : 4'h0,
                            (c == 16) ? 4'h2 : 4'h0, (c == 22) ? 4'h2 : 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL glitch edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    task automatic test_holdoff();
        exp_t e;
        exp_t got;
        logic [3:0] v;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            v = 4'h3;
            if (c == 7 || c == 8) v[0] = 1'b0;
            if (c >= 5 && c <= 8) v[1] = 1'b0;
            rawIn = v;
            sb.push_back(mk((c >= 6) ? 4'h3 : 4'h0, (c == 6) ? 4'h3 : 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL holdoff edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            rawIn = 4'hC;
            sb.push_back(mk((c >= 6) ? 4'hC : 4'h0, (c == 6) ? 4'hC : 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simultaneous edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    task automatic test_tick();
        exp_t e;
        exp_t got;
        logic [3:0] v;
        do_reset();
        // ch0 clean; ch1 has a one-clk low gap between ticks that must clear its count
        for (int c = 1; c <= 26; c++) begin
            tick = (c % 4 == 0);
            v = 4'h3;
            if (c == 7) v[1] = 1'b0;
            rawIn = v;
            sb.push_back(mk({2'b00, (c >= 24), (c >= 16)}, {2'b00, (c == 24), (c == 16)}, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tick_gated edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) rstN = 1'b0;
            tick  = (c % 4 == 0);
            rawIn = 4'h1;
            sb.push_back(mk(4'h0, 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tick_midreset edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
        rstN = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick  = (c % 4 == 0);
            rawIn = 4'h1;
            sb.push_back(mk((c >= 16) ? 4'h1 : 4'h0, (c == 16) ? 4'h1 : 4'h0, 4'h0));
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {level, rise, fall, anyRise};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tick_restart edge=%0d got lvl=%h r=%h f=%h a=%b exp lvl=%h r=%h f=%h a=%b",
                         c, level, rise, fall, anyRise, e.lvl, e.r, e.f, e.a);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_holdoff();
        test_back_to_back();
        test_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
